// File: rtl/pwm_meter.sv
// pwm_meter: measures period and high time of sig_in in clk cycles and strobes valid per closed period.
// Optional duty classifier compiled in with PWM_METER_DUTY_DECODE_EN.
module pwm_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             valid,
    output logic             busy,
    output logic             stuck
`ifdef PWM_METER_DUTY_DECODE_EN
    ,
    output logic [1:0]       duty_code
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             stuck_q, stuck_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             rise, fall;
    logic             close;

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        hcnt_d  = hcnt_q;
        per_d   = per_q;
        hi_d    = hi_q;
        valid_d = 1'b0;
        stuck_d = stuck_q;
        close   = 1'b0;
        if (!meas_en) begin
            state_d = S_IDLE;
            pcnt_d  = '0;
            hcnt_d  = '0;
            stuck_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                    pcnt_d  = '0;
                    hcnt_d  = '0;
                end
                S_ARM: begin
                    if (rise) begin
                        state_d = S_HIGH;
                        pcnt_d  = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (pcnt_q == CNT_MAX) begin
                        stuck_d = 1'b1;
                        state_d = S_ARM;
                    end else begin
                        pcnt_d = pcnt_q + CNT_ONE;
                        if (fall) state_d = S_LOW;
                        else      hcnt_d  = hcnt_q + CNT_ONE;
                    end
                end
                S_LOW: begin
                    // A rise on the saturation cycle is still a genuine edge, so it closes the period.
                    if (rise) begin
                        close   = 1'b1;
                        per_d   = pcnt_q;
                        hi_d    = hcnt_q;
                        valid_d = 1'b1;
                        pcnt_d  = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                        state_d = S_HIGH;
                    end else if (pcnt_q == CNT_MAX) begin
                        stuck_d = 1'b1;
                        state_d = S_ARM;
                    end else begin
                        pcnt_d = pcnt_q + CNT_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            state_q <= S_IDLE;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
            per_q   <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            hcnt_q  <= hcnt_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            stuck_q <= stuck_d;
        end
    end

    assign period_cnt = per_q;
    assign high_cnt   = hi_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign stuck      = stuck_q;

`ifdef PWM_METER_DUTY_DECODE_EN
    localparam int XW = CNT_W + 6;

    logic [XW-1:0] h40, p7, p15, p25;
    logic [1:0]    duty_q, duty_d;

    // Thresholds sit midway between the generator's 10/25/50/75 % duty settings.
    assign h40 = XW'(hcnt_q) * XW'(40);
    assign p7  = XW'(pcnt_q) * XW'(7);
    assign p15 = XW'(pcnt_q) * XW'(15);
    assign p25 = XW'(pcnt_q) * XW'(25);

    always_comb begin
        duty_d = duty_q;
        if (close) begin
            if      (h40 < p7)  duty_d = 2'b11;
            else if (h40 < p15) duty_d = 2'b10;
            else if (h40 < p25) duty_d = 2'b00;
            else                duty_d = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) duty_q <= 2'b00;
        else        duty_q <= duty_d;
    end

    assign duty_code = duty_q;
`endif

endmodule
